// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: NCH write-back channels plus a stage valid bit,
// with stall/bubble/flush handling and saturating bubble/hold performance counters.
module pipe_stage_reg #(
  parameter int unsigned NCH        = 2,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STALL_W    = 6,
  parameter int unsigned STAGE      = 4,
  parameter bit          CLEAR_DATA = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [STALL_W-1:0]      stall_en,
  input  logic                    flush,
  input  logic                    cnt_clr,
  input  logic                    in_valid,
  input  logic [NCH-1:0]          in_en,
  input  logic [NCH*ADDR_W-1:0]   in_addr,
  input  logic [NCH*DATA_W-1:0]   in_data,
  output logic                    out_valid,
  output logic [NCH-1:0]          out_en,
  output logic [NCH*ADDR_W-1:0]   out_addr,
  output logic [NCH*DATA_W-1:0]   out_data,
  output logic [CNT_W-1:0]        bubble_cnt,
  output logic [CNT_W-1:0]        hold_cnt
);

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_FLUSH
  } action_e;

  logic    stall_self;
  logic    stall_next;
  action_e action;

  if (NCH == 0 || STAGE >= STALL_W) begin : g_bad_params
    $error("pipe_stage_reg: NCH must be >= 1 and STAGE must be < STALL_W");
  end

  assign stall_self = stall_en[STAGE];

  // The last stage has no downstream stall bit; treat it as not stalled.
  if (STAGE + 1 < STALL_W) begin : g_next_stage
    assign stall_next = stall_en[STAGE+1];
  end else begin : g_last_stage
    assign stall_next = 1'b0;
  end

  // Decode this edge's action; flush outranks every stall pattern.
  always_comb begin
    action = ACT_ADVANCE;
    if (flush) begin
      action = ACT_FLUSH;
    end else if (stall_self && !stall_next) begin
      action = ACT_BUBBLE;
    end else if (stall_self && stall_next) begin
      action = ACT_HOLD;
    end
  end

  // Stage datapath register: advance, hold, or clear to an invalid slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_en    <= '0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      case (action)
        ACT_FLUSH, ACT_BUBBLE: begin
          out_valid <= 1'b0;
          out_en    <= '0;
          if (CLEAR_DATA) begin
            out_addr <= '0;
            out_data <= '0;
          end
        end
        ACT_HOLD: begin
        end
        default: begin
          out_valid <= in_valid;
          out_en    <= in_en & {NCH{in_valid}};
          out_addr  <= in_addr;
          out_data  <= in_data;
        end
      endcase
    end
  end

  // Saturating efficiency counters; a clear beats an increment in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      bubble_cnt <= '0;
      hold_cnt   <= '0;
    end else if (action == ACT_BUBBLE) begin
      if (bubble_cnt != '1) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end else if (action == ACT_HOLD) begin
      if (hold_cnt != '1) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: two configurations driven by shared stimulus,
// each compared every cycle against a rule-level reference model.
module tb_pipe_stage_reg;

  localparam int NCH = 2;
  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int SW  = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [SW-1:0]       stall_en;
  logic                flush;
  logic                cnt_clr;
  logic                in_valid;
  logic [NCH-1:0]      in_en;
  logic [NCH*AW-1:0]   in_addr;
  logic [NCH*DW-1:0]   in_data;

  logic                a_valid, b_valid;
  logic [NCH-1:0]      a_en, b_en;
  logic [NCH*AW-1:0]   a_addr, b_addr;
  logic [NCH*DW-1:0]   a_data, b_data;
  logic [15:0]         a_bc, a_hc;
  logic [2:0]          b_bc, b_hc;

  pipe_stage_reg #(
    .NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .STALL_W(SW),
    .STAGE(4), .CLEAR_DATA(1'b1), .CNT_W(16)
  ) dut_a (
    .clk(clk), .reset(reset), .stall_en(stall_en), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_en(in_en), .in_addr(in_addr), .in_data(in_data),
    .out_valid(a_valid), .out_en(a_en), .out_addr(a_addr), .out_data(a_data),
    .bubble_cnt(a_bc), .hold_cnt(a_hc)
  );

  pipe_stage_reg #(
    .NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .STALL_W(SW),
    .STAGE(5), .CLEAR_DATA(1'b0), .CNT_W(3)
  ) dut_b (
    .clk(clk), .reset(reset), .stall_en(stall_en), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_en(in_en), .in_addr(in_addr), .in_data(in_data),
    .out_valid(b_valid), .out_en(b_en), .out_addr(b_addr), .out_data(b_data),
    .bubble_cnt(b_bc), .hold_cnt(b_hc)
  );

  typedef struct {
    bit              v;
    bit [NCH-1:0]    en;
    bit [NCH*AW-1:0] addr;
    bit [NCH*DW-1:0] data;
    int unsigned     bc;
    int unsigned     hc;
  } mstate_t;

  mstate_t ma, mb;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Next state of one stage from the behavioural rules, using the current inputs.
  function automatic mstate_t step(mstate_t c, int unsigned stage, bit clear, int unsigned cmax);
    mstate_t  r;
    bit [SW:0] ext;
    bit        s, n;
    r   = c;
    ext = {1'b0, stall_en};
    s   = ext[stage];
    n   = ext[stage+1];
    if (reset) begin
      r = '{default: 0};
      return r;
    end
    if (cnt_clr) begin
      r.bc = 0;
      r.hc = 0;
    end else if (!flush && s && !n) begin
      if (r.bc < cmax) r.bc = r.bc + 1;
    end else if (!flush && s && n) begin
      if (r.hc < cmax) r.hc = r.hc + 1;
    end
    if (flush || (s && !n)) begin
      r.v  = 0;
      r.en = '0;
      if (clear) begin
        r.addr = '0;
        r.data = '0;
      end
    end else if (!s) begin
      r.v    = in_valid;
      r.en   = in_valid ? in_en : '0;
      r.addr = in_addr;
      r.data = in_data;
    end
    return r;
  endfunction

  task automatic compare_all();
    check("a.valid", 64'(a_valid), 64'(ma.v));
    check("a.en",    64'(a_en),    64'(ma.en));
    check("a.addr",  64'(a_addr),  64'(ma.addr));
    check("a.data",  64'(a_data),  64'(ma.data));
    check("a.bcnt",  64'(a_bc),    64'(ma.bc));
    check("a.hcnt",  64'(a_hc),    64'(ma.hc));
    check("b.valid", 64'(b_valid), 64'(mb.v));
    check("b.en",    64'(b_en),    64'(mb.en));
    check("b.addr",  64'(b_addr),  64'(mb.addr));
    check("b.data",  64'(b_data),  64'(mb.data));
    check("b.bcnt",  64'(b_bc),    64'(mb.bc));
    check("b.hcnt",  64'(b_hc),    64'(mb.hc));
  endtask

  task automatic cycle();
    @(posedge clk);
    ma = step(ma, 4, 1'b1, 16'hFFFF);
    mb = step(mb, 5, 1'b0, 7);
    #1;
    compare_all();
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    reset    = 1'b1;
    stall_en = '0;
    flush    = 1'b0;
    cnt_clr  = 1'b0;
    in_valid = 1'b1;
    in_en    = 2'b11;
    in_addr  = {5'd7, 5'd3};
    in_data  = {32'h1234_5678, 32'hDEAD_BEEF};

    // Reset with nonzero inputs.
    repeat (2) cycle();
    check("rst.a_data", 64'(a_data), 64'd0);
    check("rst.b_bcnt", 64'(b_bc), 64'd0);
    reset = 1'b0;

    // First advance after release.
    cycle();
    check("adv.a_data0", 64'(a_data[31:0]), 64'hDEAD_BEEF);
    check("adv.a_addr0", 64'(a_addr[4:0]), 64'd3);

    // Hold for stage 4, bubble for stage 5.
    stall_en = 6'b110000;
    repeat (3) cycle();
    check("hold.a_hcnt", 64'(a_hc), 64'd3);
    check("hold.a_data0", 64'(a_data[31:0]), 64'hDEAD_BEEF);

    // Bubble for stage 4, advance for stage 5.
    stall_en = 6'b010000;
    cycle();
    check("bub.a_bcnt", 64'(a_bc), 64'd1);
    check("bub.a_data", 64'(a_data), 64'd0);
    check("bub.a_en", 64'(a_en), 64'd0);

    // Flush together with a bubble pattern.
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush.a_bcnt", 64'(a_bc), 64'd1);
    check("flush.b_data0", 64'(b_data[31:0]), 64'hDEAD_BEEF);
    check("flush.b_en", 64'(b_en), 64'd0);

    // Nine consecutive bubbles on the last stage with a 3-bit counter.
    stall_en = 6'b100000;
    repeat (9) cycle();
    check("sat.b_bcnt", 64'(b_bc), 64'd7);

    // Counter clear during a bubble cycle.
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    check("clr.b_bcnt", 64'(b_bc), 64'd0);

    // Invalid input gating.
    stall_en = '0;
    in_valid = 1'b0;
    in_en    = 2'b11;
    in_addr  = {5'd17, 5'd9};
    in_data  = {32'hCAFE_F00D, 32'h0BAD_F00D};
    cycle();
    check("inv.a_en", 64'(a_en), 64'd0);
    check("inv.a_valid", 64'(a_valid), 64'd0);
    check("inv.a_data", 64'(a_data), {32'hCAFE_F00D, 32'h0BAD_F00D});

    // Randomized phase with a monotone stall vector.
    for (int i = 0; i < 1500; i++) begin
      int k;
      k        = $urandom_range(0, 6);
      stall_en = SW'((1 << k) - 1);
      reset    = ($urandom_range(0, 99) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      cnt_clr  = ($urandom_range(0, 31) == 0);
      in_valid = 1'($urandom);
      in_en    = NCH'($urandom);
      in_addr  = (NCH*AW)'($urandom);
      in_data  = {$urandom, $urandom};
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register, the generic successor to the fixed MEM/WB latch.
- Carries NCH independent write-back channels (GPR, HI/LO, CP0, …), each with enable, address and data, plus a stage valid bit.
- Stall, bubble and flush are driven by the CPU-wide stall vector and a flush line from the control unit.
- Saturating bubble and hold counters expose pipeline-efficiency data to the debug/CP0 read path.

Parameters:
- NCH, 2, number of write-back channels (>=1).
- ADDR_W, 5, address width per channel.
- DATA_W, 32, data width per channel.
- STALL_W, 6, width of the stall vector.
- STAGE, 4, index of this stage's bit in the stall vector (0..STALL_W-1).
- CLEAR_DATA, 1, 1: bubble/flush zeroes addr/data; 0: only valid/enables cleared, addr/data hold.
- CNT_W, 16, width of the performance counters.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- stall_en, input, STALL_W, CPU stall vector; bit i=1 stalls stage i.
- flush, input, 1, exception/branch flush of this stage.
- cnt_clr, input, 1, synchronous clear of both counters.
- in_valid, input, 1, upstream stage holds a real instruction.
- in_en, input, NCH, per-channel write enables (channel k = bit k).
- in_addr, input, NCH*ADDR_W, channel k at [k*ADDR_W +: ADDR_W].
- in_data, input, NCH*DATA_W, channel k at [k*DATA_W +: DATA_W].
- out_valid, output, 1, registered valid.
- out_en, output, NCH, registered enables.
- out_addr, output, NCH*ADDR_W, registered addresses.
- out_data, output, NCH*DATA_W, registered data.
- bubble_cnt, output, CNT_W, number of bubbles inserted.
- hold_cnt, output, CNT_W, number of hold cycles.

Behaviour:
- Definitions:
  - s = stall_en[STAGE].
  - n = stall_en[STAGE+1]; n = 0 when STAGE = STALL_W-1.
- Action per edge, evaluated in priority order (first match wins):
  1. reset: all outputs 0, both counters 0.
  2. flush: out_valid=0, out_en=0; addr/data zeroed if CLEAR_DATA else held. Not counted as a bubble.
  3. bubble (s && !n): same register effect as flush; bubble_cnt += 1.
  4. hold (s && n): all registers keep value; hold_cnt += 1.
  5. advance (!s): out_valid<=in_valid; out_en<=in_en & {NCH{in_valid}}; out_addr<=in_addr; out_data<=in_data.
- Latency: 1 cycle from input to output on advance; no combinational input-to-output path.
- Invalid-input gating:
  - Enables are forced to 0 when in_valid=0.
  - addr/data are still captured.
  - Downstream must qualify on out_en only.
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - cnt_clr zeroes both counters, taking priority over an increment in the same cycle.
  - cnt_clr does not affect the datapath registers.
  - cnt_clr during reset: reset wins (same result).
- Simultaneous events:
  - flush with any stall pattern: flush wins; the counters do not change.
  - Reset mid-stall: reset wins; the stage advances normally on the first cycle after reset if s=0.
- Channel independence: each channel's en/addr/data follows the same rule; no cross-channel interaction.
- Elaboration checks: STAGE >= STALL_W or NCH = 0 is illegal and must be rejected by an elaboration-time check.
- Stall vector: assumed monotone (stage i stalled implies all earlier stages stalled); no behaviour is defined beyond the rules above for a non-monotone vector.

Test Plan:
- Reset:
  - Stimulus: reset=1 for 2 cycles with in_* nonzero.
  - Required: all out_* = 0, bubble_cnt = hold_cnt = 0; first advance after release shows in_* on the next edge.
- Advance/hold/bubble, defaults:
  - Stimulus: in_valid=1, in_en=2'b11, ch0 addr=5'd3, data=32'hDEAD_BEEF; then stall_en=6'b110000 for 3 cycles; then 6'b010000.
  - Required: the values are latched, held for 3 cycles with hold_cnt=3, then bubble gives out_valid=0, out_en=0, addr/data=0, bubble_cnt=1.
- Flush priority:
  - Stimulus: flush=1 together with stall_en=6'b010000.
  - Required: outputs cleared, bubble_cnt unchanged.
  - Stimulus: repeat with CLEAR_DATA=0.
  - Required: out_data retains 32'hDEAD_BEEF while out_en=0.
- Invalid gating:
  - Stimulus: in_valid=0, in_en=2'b11, advance.
  - Required: out_en=2'b00, out_valid=0, out_addr/out_data equal the inputs.
- Last-stage boundary:
  - Stimulus: STAGE=5, STALL_W=6, stall_en[5]=1.
  - Required: bubble inserted every cycle (n treated as 0); bubble_cnt increments each cycle.
- Counter saturation/clear:
  - Stimulus: CNT_W=3, 9 consecutive bubbles.
  - Required: bubble_cnt stops at 7.
  - Stimulus: cnt_clr asserted in a bubble cycle.
  - Required: bubble_cnt = 0 on the following cycle.
